rr_grant_sequencer: RTL and testbench



---
 rtl/rr_grant_sequencer_pkg.sv | 16 +
 rtl/rr_grant_sequencer_if.sv | 30 +++
 rtl/rr_grant_sequencer_next_idx.sv | 28 ++
 rtl/rr_grant_sequencer.sv | 141 ++++++++++++++
 tb/tb_rr_grant_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_grant_sequencer_pkg.sv
// Shared definitions for the round-robin grant sequencer and related arbiters.
package rr_grant_sequencer_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  // Pointer reset value: the first search after reset starts at requester 0.
  localparam logic [IDX_W-1:0] LAST_RST = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

endpackage

// File: rtl/rr_grant_sequencer_if.sv
// Request/grant bundle between requesters and the grant sequencer.
interface rr_grant_sequencer_if;
  import rr_grant_sequencer_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_en;
  logic             busy;
  logic             timeout;

  modport master (
    output req,
    output done,
    input  grant_idx,
    input  grant_en,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant_idx,
    output grant_en,
    output busy,
    output timeout
  );

endinterface

// File: rtl/rr_grant_sequencer_next_idx.sv
// rr_next_idx: rotate-and-priority-encode. Picks the first set request bit
// scanning upward from (last+1) with wrap; 'last' itself has lowest priority.
module rr_next_idx
  import rr_grant_sequencer_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_any_req
);

  logic [IDX_W-1:0] w_idx;

  // Scan from farthest to nearest so the nearest set bit after 'last' wins.
  always_comb begin
    o_winner = '0;
    w_idx    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_idx = i_last + IDX_W'(i);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
      end
    end
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/rr_grant_sequencer.sv
// rr_grant_sequencer: 8-way round-robin arbiter driving a 3-to-8 decoder.
// Grants are held until done, owner request drop, or (with GRANT_TIMEOUT_EN
// defined) MAX_GRANT cycles; one dead cycle separates consecutive grants.
//
//   state  | meaning
//   IDLE   | no grant; arbitrate among pending requests
//   GRANT  | grant_en high for grant_idx; watch release conditions
//   GAP    | one dead cycle with grant_en low before re-arbitration
module rr_grant_sequencer
  import rr_grant_sequencer_pkg::*;
#(
  parameter int unsigned MAX_GRANT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  rr_grant_sequencer_if.slave        io_arb
);

  if ((MAX_GRANT < 1) || (MAX_GRANT > 255)) begin : g_bad_max_grant
    $error("MAX_GRANT must be within 1..255");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] w_grant_idx_nxt;
  logic             r_grant_en;
  logic             w_grant_en_nxt;
  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] w_last_nxt;

  logic [IDX_W-1:0] w_winner;
  logic             w_any_req;
  logic             w_rel_done;
  logic             w_rel_drop;

`ifdef GRANT_TIMEOUT_EN
  localparam logic [7:0] TMR_LAST = 8'(MAX_GRANT - 1);

  logic [7:0] r_timer;
  logic [7:0] w_timer_nxt;
  logic       r_timeout;
  logic       w_timeout_nxt;
  logic       w_rel_tmo;

  assign w_rel_tmo = (r_timer == TMR_LAST);
`endif

  rr_next_idx u_next_idx (
    .i_req     (io_arb.req),
    .i_last    (r_last),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  assign w_rel_done = io_arb.done;
  assign w_rel_drop = ~io_arb.req[r_grant_idx];

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grant_idx <= '0;
      r_grant_en  <= 1'b0;
      r_last      <= LAST_RST;
`ifdef GRANT_TIMEOUT_EN
      r_timer     <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_grant_en  <= w_grant_en_nxt;
      r_last      <= w_last_nxt;
`ifdef GRANT_TIMEOUT_EN
      r_timer     <= w_timer_nxt;
      r_timeout   <= w_timeout_nxt;
`endif
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_idx_nxt = r_grant_idx;
    w_grant_en_nxt  = r_grant_en;
    w_last_nxt      = r_last;
`ifdef GRANT_TIMEOUT_EN
    w_timer_nxt     = r_timer;
    w_timeout_nxt   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_grant_idx_nxt = w_winner;
          w_grant_en_nxt  = 1'b1;
          w_last_nxt      = w_winner;
          w_state_nxt     = ST_GRANT;
`ifdef GRANT_TIMEOUT_EN
          w_timer_nxt     = '0;
`endif
        end
      end
      ST_GRANT: begin
`ifdef GRANT_TIMEOUT_EN
        if (w_rel_done || w_rel_drop || w_rel_tmo) begin
          w_grant_en_nxt = 1'b0;
          w_state_nxt    = ST_GAP;
          // Timer-only release is reported; owner-initiated release is not.
          w_timeout_nxt  = w_rel_tmo & ~w_rel_done & ~w_rel_drop;
        end else begin
          w_timer_nxt = (r_timer == 8'hFF) ? r_timer : (r_timer + 8'd1);
        end
`else
        if (w_rel_done || w_rel_drop) begin
          w_grant_en_nxt = 1'b0;
          w_state_nxt    = ST_GAP;
        end
`endif
      end
      ST_GAP: begin
        w_grant_en_nxt = 1'b0;
        w_state_nxt    = ST_IDLE;
      end
      default: begin
        w_grant_en_nxt = 1'b0;
        w_state_nxt    = ST_IDLE;
      end
    endcase
  end

  assign io_arb.grant_idx = r_grant_idx;
  assign io_arb.grant_en  = r_grant_en;
  assign io_arb.busy      = (r_state == ST_GRANT) || (r_state == ST_GAP);
`ifdef GRANT_TIMEOUT_EN
  assign io_arb.timeout   = r_timeout;
`else
  assign io_arb.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Testbench for rr_grant_sequencer (MAX_GRANT=4). Expected grant indices are
// queued when requests are driven and compared on each rising grant_en.
module tb_rr_grant_sequencer;

  typedef struct {
    logic [7:0] req;
    logic [2:0] exp_idx;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [2:0] exp_q[$];
  logic       sb_on;
  logic       prev_en;
  logic [2:0] sb_exp;

  vec_t tbl[12];

  rr_grant_sequencer_if u_if ();

  rr_grant_sequencer #(.MAX_GRANT(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_arb (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_grant(input string name, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (u_if.grant_en === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL %s no grant within 20 cycles", name);
  endtask

  // Scoreboard: each new grant must match the oldest queued expectation.
  always @(negedge clk) begin
    if (sb_on) begin
      if (u_if.grant_en === 1'b1 && prev_en !== 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got idx %0d expected no grant", u_if.grant_idx);
        end else begin
          sb_exp = exp_q.pop_front();
          if (u_if.grant_idx !== sb_exp) begin
            errors++;
            $display("FAIL sb_idx got %0d expected %0d", u_if.grant_idx, sb_exp);
          end
        end
      end
      prev_en = u_if.grant_en;
    end
  end

  initial begin
    int n;
    int hi;
    logic ok;
    logic seen;

    checks  = 0;
    errors  = 0;
    sb_on   = 1'b0;
    prev_en = 1'b0;

    tbl[0]  = '{8'hFF, 3'd0};
    tbl[1]  = '{8'hFF, 3'd1};
    tbl[2]  = '{8'h01, 3'd0};
    tbl[3]  = '{8'h81, 3'd7};
    tbl[4]  = '{8'h81, 3'd0};
    tbl[5]  = '{8'h10, 3'd4};
    tbl[6]  = '{8'h18, 3'd3};
    tbl[7]  = '{8'h18, 3'd4};
    tbl[8]  = '{8'h40, 3'd6};
    tbl[9]  = '{8'h41, 3'd0};
    tbl[10] = '{8'h41, 3'd6};
    tbl[11] = '{8'h41, 3'd0};

    // Reset held two cycles with all requests pending.
    rst_n     = 1'b0;
    u_if.req  = 8'hFF;
    u_if.done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_en",   u_if.grant_en,  0);
      chk("rst_idx",  u_if.grant_idx, 0);
      chk("rst_busy", u_if.busy,      0);
      chk("rst_tmo",  u_if.timeout,   0);
    end
    rst_n = 1'b1;
    sb_on = 1'b1;

    // Table: one grant per entry, released by a done pulse.
    for (int k = 0; k < 12; k++) begin
      u_if.req = tbl[k].req;
      exp_q.push_back(tbl[k].exp_idx);
      wait_grant("tbl_wait", n);
      chk("tbl_latency", n, 1);
      chk("tbl_busy", u_if.busy, 1);
      u_if.done = 1'b1;
      step();
      u_if.done = 1'b0;
      chk("tbl_gap_en",   u_if.grant_en, 0);
      chk("tbl_gap_busy", u_if.busy,     1);
      chk("tbl_gap_tmo",  u_if.timeout,  0);
      step();
      chk("tbl_idle_busy", u_if.busy,     0);
      chk("tbl_idle_en",   u_if.grant_en, 0);
    end
    u_if.req = 8'h00;
    step();

    // Rotation with a held request set.
    u_if.req = 8'b1010_0100;
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd2);
    for (int k = 0; k < 4; k++) begin
      wait_grant("rot_wait", n);
      chk("rot_spacing", n, (k == 0) ? 1 : 2);
      if (k == 3) u_if.req = 8'h00;
      u_if.done = 1'b1;
      step();
      u_if.done = 1'b0;
      chk("rot_gap_en",   u_if.grant_en, 0);
      chk("rot_gap_busy", u_if.busy,     1);
    end
    step();

    // Owner drops its request.
    u_if.req = 8'h08;
    exp_q.push_back(3'd3);
    wait_grant("drop_wait", n);
    u_if.req = 8'h00;
    step();
    chk("drop_en",   u_if.grant_en,  0);
    chk("drop_tmo",  u_if.timeout,   0);
    chk("drop_busy", u_if.busy,      1);
    chk("drop_idx",  u_if.grant_idx, 3);
    step();
    chk("drop_idle_busy", u_if.busy, 0);

    // Other requests arriving during a grant do not preempt.
    u_if.req = 8'h10;
    exp_q.push_back(3'd4);
    wait_grant("hold_wait", n);
    u_if.req = 8'hFF;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (u_if.grant_en !== 1'b1 || u_if.grant_idx !== 3'd4) ok = 1'b0;
    end
    chk("hold_no_preempt", ok, 1);
    u_if.done = 1'b1;
    exp_q.push_back(3'd5);
    step();
    u_if.done = 1'b0;
    chk("hold_gap_en", u_if.grant_en, 0);
    wait_grant("hold_next", n);
    chk("hold_next_spacing", n, 2);
    u_if.req  = 8'h00;
    u_if.done = 1'b1;
    step();
    u_if.done = 1'b0;
    step();

`ifdef GRANT_TIMEOUT_EN
    // Timer expiry with a persistent requester.
    u_if.req = 8'h02;
    exp_q.push_back(3'd1);
    wait_grant("tmo_wait", n);
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (u_if.grant_en === 1'b1) hi++;
      else break;
    end
    chk("tmo_high_cycles", hi, 4);
    chk("tmo_pulse", u_if.timeout, 1);
    exp_q.push_back(3'd1);
    step();
    chk("tmo_single", u_if.timeout, 0);
    chk("tmo_idle_en", u_if.grant_en, 0);
    wait_grant("tmo_regrant", n);
    chk("tmo_regrant_lat", n, 1);
    for (int i = 0; i < 3; i++) step();
    u_if.done = 1'b1;
    step();
    u_if.done = 1'b0;
    chk("simul_en",  u_if.grant_en, 0);
    chk("simul_tmo", u_if.timeout,  0);
    u_if.req = 8'h00;
    step();
`else
    // Without the timer a grant is held indefinitely.
    u_if.req = 8'h02;
    exp_q.push_back(3'd1);
    wait_grant("notmo_wait", n);
    ok   = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (u_if.grant_en !== 1'b1) ok = 1'b0;
      if (u_if.timeout !== 1'b0) seen = 1'b1;
    end
    chk("notmo_held", ok, 1);
    chk("notmo_never", seen, 0);
    u_if.req  = 8'h00;
    u_if.done = 1'b1;
    step();
    u_if.done = 1'b0;
    step();
`endif

    // Reset during a grant.
    u_if.req = 8'hFF;
    exp_q.push_back(3'd2);
    wait_grant("mid_wait", n);
    rst_n = 1'b0;
    step();
    chk("mid_rst_en",   u_if.grant_en,  0);
    chk("mid_rst_busy", u_if.busy,      0);
    chk("mid_rst_idx",  u_if.grant_idx, 0);
    rst_n = 1'b1;
    exp_q.push_back(3'd0);
    wait_grant("mid_regrant", n);
    chk("mid_regrant_lat", n, 1);
    u_if.req  = 8'h00;
    u_if.done = 1'b1;
    step();
    u_if.done = 1'b0;
    step();

    chk("sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
